// File: rtl/unidade_load_store_if.sv
// Core-side request/response and data-memory signals of the load/store unit.
// The master modport is the core/memory side; the slave modport is the unit.
interface unidade_load_store_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        erro;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_wr;
    logic [31:0] mem_rd;

    modport master (
        output req, we, funct3, addr, wdata, mem_rd,
        input  busy, done, rdata, erro, mem_addr, mem_wd, mem_wr
    );

    modport slave (
        input  req, we, funct3, addr, wdata, mem_rd,
        output busy, done, rdata, erro, mem_addr, mem_wd, mem_wr
    );
endinterface

// File: rtl/unidade_load_store.sv
// RISC-V style load/store unit: byte/half/word loads, read-modify-write sub-word stores.
// Define MISALIGN_TRAP_EN to trap misaligned H/HU/W accesses instead of aligning them.
module unidade_load_store (
    input  logic clk,
    input  logic rst,
    unidade_load_store_if.slave bus
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        LEITURA = 2'b01,
        ESCRITA = 2'b10,
        CONCLUI = 2'b11
    } estado_t;

    estado_t     state_r, next_state_s;

    logic        we_r;
    logic [2:0]  f3_r;
    logic [1:0]  lane_r;
    logic [31:0] wdata_r;
    logic        busy_r, done_r, erro_r, mem_wr_r;
    logic [31:0] rdata_r, mem_addr_r, mem_wd_r;

    logic        valid_f3_s, misalign_s, fault_s, is_word_s;

    // Load extraction: byte lane addr[1:0], halfword lane addr[1]; low bits beyond that are ignored.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Store merge: only the addressed lane of the read word is replaced.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] data,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [31:0] r;
        r = word;
        case (f3[1:0])
            2'b00:   r[{lane, 3'b000} +: 8] = data[7:0];
            2'b01:   r = lane[1] ? {data[15:0], word[15:0]} : {word[31:16], data[15:0]};
            default: r = data;
        endcase
        return r;
    endfunction

    // Classify the request presented in OCIOSO.
    always_comb begin
        case (bus.funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: valid_f3_s = 1'b1;
            default:                                 valid_f3_s = 1'b0;
        endcase
`ifdef MISALIGN_TRAP_EN
        misalign_s = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                     ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
        misalign_s = 1'b0;
`endif
        fault_s   = !valid_f3_s || misalign_s;
        is_word_s = (bus.funct3[1:0] == 2'b10);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= OCIOSO;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; sub-word stores read the word first, full-word stores write directly.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            OCIOSO: begin
                if (bus.req) begin
                    if (fault_s) begin
                        next_state_s = CONCLUI;
                    end else if (!bus.we) begin
                        next_state_s = LEITURA;
                    end else if (is_word_s) begin
                        next_state_s = ESCRITA;
                    end else begin
                        next_state_s = LEITURA;
                    end
                end else begin
                    next_state_s = OCIOSO;
                end
            end
            LEITURA: begin
                if (we_r) begin
                    next_state_s = ESCRITA;
                end else begin
                    next_state_s = CONCLUI;
                end
            end
            ESCRITA: next_state_s = CONCLUI;
            CONCLUI: next_state_s = OCIOSO;
            default: next_state_s = OCIOSO;
        endcase
    end

    // Request latch, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_r       <= 1'b0;
            f3_r       <= 3'b000;
            lane_r     <= 2'b00;
            wdata_r    <= 32'h0000_0000;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            erro_r     <= 1'b0;
            mem_wr_r   <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            mem_addr_r <= 32'h0000_0000;
            mem_wd_r   <= 32'h0000_0000;
        end else begin
            busy_r   <= (next_state_s != OCIOSO);
            done_r   <= (next_state_s == CONCLUI);
            mem_wr_r <= (next_state_s == ESCRITA);
            erro_r   <= (state_r == OCIOSO) && bus.req && fault_s;
            case (state_r)
                OCIOSO: begin
                    if (bus.req) begin
                        we_r       <= bus.we;
                        f3_r       <= bus.funct3;
                        lane_r     <= bus.addr[1:0];
                        wdata_r    <= bus.wdata;
                        mem_addr_r <= {2'b00, bus.addr[31:2]};
                        if (bus.we && is_word_s && !fault_s) begin
                            mem_wd_r <= bus.wdata;
                        end else begin
                            mem_wd_r <= mem_wd_r;
                        end
                    end else begin
                        we_r <= we_r;
                    end
                end
                LEITURA: begin
                    if (we_r) begin
                        mem_wd_r <= store_merge(bus.mem_rd, wdata_r, f3_r, lane_r);
                    end else begin
                        rdata_r <= load_extract(bus.mem_rd, f3_r, lane_r);
                    end
                end
                default: begin
                    rdata_r <= rdata_r;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.erro     = erro_r;
    assign bus.rdata    = rdata_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.mem_wd   = mem_wd_r;
    assign bus.mem_wr   = mem_wr_r;

endmodule

// File: tb/tb_unidade_load_store.sv
// Scoreboard bench for unidade_load_store: expected completions and memory writes are
// queued at issue time and compared when the unit signals done / mem_wr.
module tb_unidade_load_store;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_errors;
    int   wr_cnt;

    typedef struct {
        logic [31:0] rdata;
        logic        erro;
        int          issue;
        int          lat;
        int          nwr;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] wr_q[$];
    logic [31:0] mem [0:15];

    unidade_load_store_if bus ();

    unidade_load_store dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: combinational read, write port inhibited while system reset is held.
    assign bus.mem_rd = mem[bus.mem_addr[3:0]];
    always @(posedge clk) begin
        if (bus.mem_wr && !rst) mem[bus.mem_addr[3:0]] <= bus.mem_wd;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Monitor: compare memory writes and completions against the queued expectations.
    always @(negedge clk) begin
        if (bus.mem_wr) begin
            wr_cnt++;
            if (wr_q.size() == 0) begin
                check_eq("unexpected_wr", 32'd1, 32'd0);
            end else begin
                logic [63:0] w;
                w = wr_q.pop_front();
                check_eq("wr_addr", bus.mem_addr, w[63:32]);
                check_eq("wr_data", bus.mem_wd, w[31:0]);
            end
        end
        if (bus.done) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("rdata", bus.rdata, e.rdata);
                check_eq("erro", {31'd0, bus.erro}, {31'd0, e.erro});
                check_eq("latency", cyc - e.issue, e.lat);
                check_eq("wr_pulses", wr_cnt, e.nwr);
            end
            wr_cnt = 0;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            check_eq("done_timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] er, input logic ee,
                         input int lat, input int nwr, input logic [31:0] wa,
                         input logic [31:0] wd);
        exp_t e;
        @(negedge clk);
        bus.we = w; bus.funct3 = f; bus.addr = a; bus.wdata = d; bus.req = 1'b1;
        e.rdata = er; e.erro = ee; e.issue = cyc; e.lat = lat; e.nwr = nwr;
        sb_q.push_back(e);
        if (nwr != 0) wr_q.push_back({wa, wd});
        @(negedge clk);
        bus.req = 1'b0;
        check_eq("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        // Scramble inputs: the latched request must be unaffected.
        bus.we = 1'($urandom); bus.funct3 = 3'($urandom);
        bus.addr = $urandom; bus.wdata = $urandom;
        wait_idle();
    endtask

    initial begin
        cyc = 0; n_checks = 0; n_errors = 0; wr_cnt = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0000_0000;
        mem[1] = 32'h1111_1111;
        mem[2] = 32'h0000_A5A5;
        mem[3] = 32'h80FF_7F01;
        bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'b000;
        bus.addr = 32'h0; bus.wdata = 32'h0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("rst_done", {31'd0, bus.done}, 32'd0);
        check_eq("rst_erro", {31'd0, bus.erro}, 32'd0);
        check_eq("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        check_eq("rst_rdata", bus.rdata, 32'h0);
        check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
        check_eq("rst_mem_wd", bus.mem_wd, 32'h0);
        rst = 1'b0;

        // Loads of every width and lane.
        issue(1'b0, 3'b100, 32'd8,  32'h0, 32'h0000_00A5, 1'b0, 2, 0, 32'h0, 32'h0);
        issue(1'b0, 3'b000, 32'd8,  32'h0, 32'hFFFF_FFA5, 1'b0, 2, 0, 32'h0, 32'h0);
        issue(1'b0, 3'b001, 32'd8,  32'h0, 32'hFFFF_A5A5, 1'b0, 2, 0, 32'h0, 32'h0);
        issue(1'b0, 3'b101, 32'd8,  32'h0, 32'h0000_A5A5, 1'b0, 2, 0, 32'h0, 32'h0);
        issue(1'b0, 3'b010, 32'd12, 32'h0, 32'h80FF_7F01, 1'b0, 2, 0, 32'h0, 32'h0);
        issue(1'b0, 3'b000, 32'd13, 32'h0, 32'h0000_007F, 1'b0, 2, 0, 32'h0, 32'h0);
        issue(1'b0, 3'b001, 32'd14, 32'h0, 32'hFFFF_80FF, 1'b0, 2, 0, 32'h0, 32'h0);
        issue(1'b0, 3'b100, 32'd15, 32'h0, 32'h0000_0080, 1'b0, 2, 0, 32'h0, 32'h0);
        // Sub-word stores (read-modify-write) and read-back.
        issue(1'b1, 3'b000, 32'd9,  32'h0000_0012, 32'h0000_0080, 1'b0, 3, 1, 32'd2, 32'h0000_12A5);
        issue(1'b0, 3'b010, 32'd8,  32'h0, 32'h0000_12A5, 1'b0, 2, 0, 32'h0, 32'h0);
        issue(1'b1, 3'b001, 32'd10, 32'h0000_BEEF, 32'h0000_12A5, 1'b0, 3, 1, 32'd2, 32'hBEEF_12A5);
        issue(1'b0, 3'b010, 32'd8,  32'h0, 32'hBEEF_12A5, 1'b0, 2, 0, 32'h0, 32'h0);
        // Invalid width codes: error, no write, rdata held.
        issue(1'b0, 3'b011, 32'd8,  32'h0, 32'hBEEF_12A5, 1'b1, 1, 0, 32'h0, 32'h0);
        issue(1'b1, 3'b111, 32'd8,  32'hFFFF_FFFF, 32'hBEEF_12A5, 1'b1, 1, 0, 32'h0, 32'h0);
`ifdef MISALIGN_TRAP_EN
        issue(1'b0, 3'b001, 32'd9,  32'h0, 32'hBEEF_12A5, 1'b1, 1, 0, 32'h0, 32'h0);
        issue(1'b1, 3'b010, 32'd12, 32'hCAFE_F00D, 32'hBEEF_12A5, 1'b0, 2, 1, 32'd3, 32'hCAFE_F00D);
`else
        issue(1'b0, 3'b001, 32'd9,  32'h0, 32'h0000_12A5, 1'b0, 2, 0, 32'h0, 32'h0);
        issue(1'b1, 3'b010, 32'd12, 32'hCAFE_F00D, 32'h0000_12A5, 1'b0, 2, 1, 32'd3, 32'hCAFE_F00D);
`endif
        issue(1'b0, 3'b010, 32'd12, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 0, 32'h0, 32'h0);

        // Reset during ESCRITA: write strobe dropped, no done, memory untouched.
        @(negedge clk);
        bus.we = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'd4; bus.wdata = 32'd100; bus.req = 1'b1;
        wr_q.push_back({32'd1, 32'd100});
        @(negedge clk);
        bus.req = 1'b0;
        check_eq("escrita_mem_wr", {31'd0, bus.mem_wr}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("abort_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        check_eq("abort_busy", {31'd0, bus.busy}, 32'd0);
        check_eq("abort_done", {31'd0, bus.done}, 32'd0);
        check_eq("abort_rdata", bus.rdata, 32'h0);
        rst = 1'b0;
        wr_cnt = 0;
        repeat (4) @(negedge clk);
        check_eq("abort_mem_word1", mem[1], 32'h1111_1111);

        // Back-to-back SW with req held high; req toggled and wdata changed while busy.
        begin
            exp_t e;
            bus.we = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'd0; bus.wdata = 32'h0000_000A; bus.req = 1'b1;
            e.rdata = 32'h0; e.erro = 1'b0; e.issue = cyc; e.lat = 2; e.nwr = 1;
            sb_q.push_back(e);
            wr_q.push_back({32'd0, 32'h0000_000A});
            @(negedge clk);
            bus.wdata = 32'h0000_000B; bus.req = 1'b0;
            @(negedge clk);
            bus.req = 1'b1;
            @(negedge clk);
            e.issue = cyc;
            sb_q.push_back(e);
            wr_q.push_back({32'd0, 32'h0000_000B});
            @(negedge clk);
            bus.req = 1'b0;
            wait_idle();
        end
        repeat (3) @(negedge clk);
        check_eq("final_mem_word0", mem[0], 32'h0000_000B);
        check_eq("final_mem_word3", mem[3], 32'hCAFE_F00D);
        check_eq("pending_writes", wr_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/unidade_load_store.md
UNIDADE_LOAD_STORE -- requirements
Module: unidade_load_store

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all ports are listed below, clock and reset first.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req  input  1  core access request; sampled only in OCIOSO.
REQ-005 we  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 addr  input  32  byte address.
REQ-008 wdata  input  32  store data, right-aligned.
REQ-009 busy  output  1  high in every state except OCIOSO.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 rdata  output  32  load result, extended per funct3; held until the next done.
REQ-012 erro  output  1  access fault flag, valid with done.
REQ-013 mem_addr  output  32  word index to data memory, equal to addr[31:2].
REQ-014 mem_wd  output  32  full word to write.
REQ-015 mem_wr  output  1  write strobe, active for exactly one cycle per store.
REQ-016 mem_rd  input  32  combinational read word from data memory.

Function
REQ-017 FSM states SHALL be OCIOSO, LEITURA, ESCRITA and CONCLUI.
REQ-018 On req in OCIOSO, the block SHALL latch we, funct3, addr and wdata; later input changes have no effect until done.
REQ-019 Transitions from OCIOSO SHALL be:
- load -> LEITURA
- SW -> ESCRITA
- SB/SH -> LEITURA
- fault -> CONCLUI
REQ-020 LEITURA SHALL capture mem_rd, then go to ESCRITA for SB/SH and to CONCLUI for loads.
REQ-021 ESCRITA SHALL assert mem_wr for one cycle, then go to CONCLUI.
REQ-022 CONCLUI SHALL pulse done, then return to OCIOSO.
REQ-023 Latency from the req cycle to done SHALL be 2 cycles for loads and SW, and 3 cycles for SB/SH.
REQ-024 Load extraction SHALL use lane addr[1:0] for bytes and addr[1] for halfwords; B/H sign-extend, BU/HU zero-extend, W passes the word through.
REQ-025 SB/SH SHALL write back the read word with only the addressed lane replaced by wdata[7:0] or wdata[15:0]; all other bytes are preserved.
REQ-026 Invalid funct3 (011, 110, 111) SHALL complete with erro=1, no memory write and rdata unchanged.
REQ-027 req while busy SHALL be ignored; req on the cycle after done SHALL be accepted.
REQ-028 mem_wr SHALL be 0 outside ESCRITA.

Reset
REQ-029 Reset SHALL set state=OCIOSO, busy=0, done=0, erro=0, mem_wr=0, rdata=0, mem_addr=0 and mem_wd=0.
REQ-030 Reset in any state, including ESCRITA, SHALL win: mem_wr=0 from the next cycle, no done is issued, and the aborted operation is discarded.

Configuration
REQ-031 Macro MISALIGN_TRAP_EN defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, SHALL complete via CONCLUI with erro=1 and no memory access; latency is 1 cycle.
REQ-032 Macro MISALIGN_TRAP_EN undefined: offending low address bits SHALL be forced to 0 (natural alignment), and erro SHALL be raised only by REQ-026.

Verification
REQ-033 Memory word2=0x0000A5A5; LBU at addr 8 -> done at cycle 2, rdata=0x000000A5, erro=0.
REQ-034 Same memory; LB at addr 8 -> rdata=0xFFFFFFA5; LH at addr 8 -> rdata=0xFFFFA5A5.
REQ-035 SB at addr 9 with wdata=0x00000012 -> single mem_wr pulse with mem_addr=2 and mem_wd=0x000012A5; done at cycle 3.
REQ-036 LH at addr 9 -> with MISALIGN_TRAP_EN: erro=1, done at cycle 1, no mem_wr; without it: halfword read from addr 8, erro=0.
REQ-037 SW at addr 4 with wdata=100, rst asserted during ESCRITA -> mem_wr=0 from the next cycle, no done, memory word1 unchanged.
REQ-038 Back-to-back: SW at addr 0, req held high throughout -> second access accepted on the cycle after done; toggling req while busy has no effect.
